// File: rtl/conv_pkg.sv
// conv_pkg: shared constants and helpers for the 1-D convolution processing element.
//   FILTER_LEN          number of window rows (taps) per filter
//   TAP_ROW0..TAP_BIAS  wr_tap_i encoding for weight-bank writes
//   accBw()             accumulator width that cannot overflow for a full window
//   reluShiftSat()      ReLU, arithmetic right shift, then clamp to the positive BW range
package conv_pkg;

  localparam int FILTER_LEN = 3;

  localparam logic [1:0] TAP_ROW0 = 2'd0;
  localparam logic [1:0] TAP_ROW1 = 2'd1;
  localparam logic [1:0] TAP_ROW2 = 2'd2;
  localparam logic [1:0] TAP_BIAS = 2'd3;

  // Each product needs 2*BW bits; summing FILTER_LEN*vecLen of them grows the
  // magnitude by at most clog2(term count) bits.
  function automatic int accBw(input int bw, input int vecLen);
    return 2 * bw + $clog2(FILTER_LEN * vecLen);
  endfunction

  // Negative sums clamp to zero before shifting, so the shifted value is never
  // negative and only the upper bound needs saturating.
  function automatic logic [31:0] reluShiftSat(input logic signed [63:0] acc,
                                               input int shift, input int bw);
    logic signed [63:0] t;
    logic signed [63:0] maxV;
    maxV = (64'sd1 <<< (bw - 1)) - 64'sd1;
    if (acc < 64'sd0) t = 64'sd0;
    else              t = acc >>> shift;
    if (t > maxV) t = maxV;
    return 32'(t);
  endfunction

endpackage

// File: rtl/dot3_tree.sv
// dot3_tree: registered 3 x VECTOR_LEN signed products (S1) followed by the
// signed sum of all products plus bias (S2).
//   clk_i     clock (data path only, no reset needed)
//   data_i    {row2,row1,row0} window elements, term t at [t*BW +: BW]
//   weight_i  matching weights, same packing as data_i
//   bias_i    bias of the filter used for these weights, captured in S1
//   sum_o     S2 result: sum of products + bias, ACC_BW bits signed
module dot3_tree
  import conv_pkg::*;
#(
  parameter int BW         = 8,
  parameter int VECTOR_LEN = 13,
  localparam int ACC_BW    = accBw(BW, VECTOR_LEN),
  localparam int NT        = FILTER_LEN * VECTOR_LEN
) (
  input  logic                     clk_i,
  input  logic [NT*BW-1:0]         data_i,
  input  logic [NT*BW-1:0]         weight_i,
  input  logic signed [ACC_BW-1:0] bias_i,
  output logic signed [ACC_BW-1:0] sum_o
);

  localparam int PW = 2 * BW;

  logic signed [PW-1:0]     prod_q [NT];
  logic signed [ACC_BW-1:0] bias_q;
  logic signed [ACC_BW-1:0] sum_d;
  logic signed [ACC_BW-1:0] sum_q;

  // Operands are sign-extended to the product width first so the multiply is
  // carried out at full 2*BW precision.
  always_ff @(posedge clk_i) begin
    for (int t = 0; t < NT; t++) begin
      prod_q[t] <= PW'($signed(data_i[t*BW +: BW])) * PW'($signed(weight_i[t*BW +: BW]));
    end
    bias_q <= bias_i;
  end

  always_comb begin
    sum_d = bias_q;
    for (int t = 0; t < NT; t++) begin
      sum_d = sum_d + ACC_BW'(prod_q[t]);
    end
  end

  always_ff @(posedge clk_i) begin
    sum_q <= sum_d;
  end

  assign sum_o = sum_q;

endmodule

// File: rtl/conv1d_pe.sv
// conv1d_pe: one quantized 3-tap x VECTOR_LEN convolution output per valid window.
//   clk_i, rst_n_i            clock, asynchronous active-low reset
//   data0_i..data2_i          window rows (oldest..newest), signed BW elements
//   valid_i                   window valid; every beat is accepted
//   wr_en_i, wr_filter_i,
//   wr_tap_i, wr_data_i       weight row / bias write port
//   data_o                    ReLU, shifted, saturated result (0..2^(BW-1)-1)
//   filter_o                  filter index that produced data_o
//   valid_o, last_o           result valid, final result of the frame
// Latency from valid_i to valid_o is 3 cycles (S1 products, S2 sum, S3 quantize).
module conv1d_pe
  import conv_pkg::*;
#(
  parameter int BW          = 8,
  parameter int FRAME_LEN   = 50,
  parameter int VECTOR_LEN  = 13,
  parameter int NUM_FILTERS = 8,
  parameter int SHIFT       = 8,
  localparam int FW         = $clog2(NUM_FILTERS),
  localparam int RW         = VECTOR_LEN * BW
) (
  input  logic          clk_i,
  input  logic          rst_n_i,
  input  logic [RW-1:0] data0_i,
  input  logic [RW-1:0] data1_i,
  input  logic [RW-1:0] data2_i,
  input  logic          valid_i,
  input  logic          wr_en_i,
  input  logic [FW-1:0] wr_filter_i,
  input  logic [1:0]    wr_tap_i,
  input  logic [RW-1:0] wr_data_i,
  output logic [BW-1:0] data_o,
  output logic [FW-1:0] filter_o,
  output logic          valid_o,
  output logic          last_o
);

  localparam int ACC_BW = accBw(BW, VECTOR_LEN);
  localparam int BCW    = $clog2(FRAME_LEN);
  localparam logic [BCW-1:0] LAST_BEAT   = BCW'(FRAME_LEN - 1);
  localparam logic [FW-1:0]  LAST_FILTER = FW'(NUM_FILTERS - 1);

  logic [RW-1:0]            wbank_q [NUM_FILTERS][FILTER_LEN];
  logic signed [ACC_BW-1:0] bbank_q [NUM_FILTERS];

  logic [BCW-1:0] beatCnt_q, beatCnt_d;
  logic [FW-1:0]  filterIdx_q, filterIdx_d;
  logic           isLast;

  logic          v1_q, last1_q, v2_q, last2_q;
  logic [FW-1:0] f1_q, f2_q;

  logic [BW-1:0] data_q, data_d;
  logic [FW-1:0] filter_q;
  logic          valid_q, last_q;

  logic signed [ACC_BW-1:0] sum2;

  // Weight bank is deliberately not reset; a write lands at this edge and is
  // seen by the S1 lookup of the very next cycle.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      if (wr_tap_i == TAP_BIAS) bbank_q[wr_filter_i] <= wr_data_i[ACC_BW-1:0];
      else                      wbank_q[wr_filter_i][wr_tap_i] <= wr_data_i;
    end
  end

  always_comb begin
    beatCnt_d   = beatCnt_q;
    filterIdx_d = filterIdx_q;
    isLast      = 1'b0;
    if (valid_i) begin
      if (beatCnt_q == LAST_BEAT) begin
        beatCnt_d   = '0;
        isLast      = (filterIdx_q == LAST_FILTER);
        filterIdx_d = isLast ? '0 : filterIdx_q + FW'(1);
      end else begin
        beatCnt_d = beatCnt_q + BCW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      beatCnt_q   <= '0;
      filterIdx_q <= '0;
      v1_q        <= 1'b0;
      last1_q     <= 1'b0;
      v2_q        <= 1'b0;
      last2_q     <= 1'b0;
    end else begin
      beatCnt_q   <= beatCnt_d;
      filterIdx_q <= filterIdx_d;
      v1_q        <= valid_i;
      last1_q     <= isLast;
      v2_q        <= v1_q;
      last2_q     <= last1_q;
    end
  end

  // Filter tags ride alongside the data and only matter when the valid bit is set.
  always_ff @(posedge clk_i) begin
    f1_q <= filterIdx_q;
    f2_q <= f1_q;
  end

  dot3_tree #(
    .BW         (BW),
    .VECTOR_LEN (VECTOR_LEN)
  ) u_dot3_tree (
    .clk_i    (clk_i),
    .data_i   ({data2_i, data1_i, data0_i}),
    .weight_i ({wbank_q[filterIdx_q][2], wbank_q[filterIdx_q][1], wbank_q[filterIdx_q][0]}),
    .bias_i   (bbank_q[filterIdx_q]),
    .sum_o    (sum2)
  );

  always_comb begin
    data_d = BW'(reluShiftSat(64'(sum2), SHIFT, BW));
  end

  // Output data holds its last valid value between results.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      data_q   <= '0;
      filter_q <= '0;
      valid_q  <= 1'b0;
      last_q   <= 1'b0;
    end else begin
      valid_q <= v2_q;
      last_q  <= v2_q & last2_q;
      if (v2_q) begin
        data_q   <= data_d;
        filter_q <= f2_q;
      end
    end
  end

  assign data_o   = data_q;
  assign filter_o = filter_q;
  assign valid_o  = valid_q;
  assign last_o   = last_q;

endmodule

// File: doc/conv1d_pe.md
Name: conv1d_pe

Overview:
- Downstream consumer of the recycler's 3-row sliding window (data0/1/2, each VECTOR_LEN x BW).
- Computes one 3-tap x VECTOR_LEN dot product per valid window, using the weights of the currently active filter.
- Adds a per-filter bias, applies ReLU, shifts and saturates to BW bits.
- Emits one quantized output per window, tagged with its filter index and an end-of-frame marker. Output feeds the next layer's input buffer.

Parameters:
- BW, 8: signed element width of data and weights.
- FRAME_LEN, 50: valid windows per filter pass.
- VECTOR_LEN, 13: elements per window row.
- NUM_FILTERS, 8: filters per frame; also weight bank depth.
- SHIFT, 8: arithmetic right shift applied after ReLU.

Ports:
- clk_i  in  1  clock.
- rst_n_i  in  1  reset, asynchronous, active-low.
- data0_i  in  VECTOR_LEN*BW  window row 0 (oldest), signed elements, element k at bits [k*BW +: BW].
- data1_i  in  VECTOR_LEN*BW  window row 1.
- data2_i  in  VECTOR_LEN*BW  window row 2 (newest).
- valid_i  in  1  window valid.
- wr_en_i  in  1  weight/bias write strobe.
- wr_filter_i  in  clog2(NUM_FILTERS)  target filter.
- wr_tap_i  in  2  0..2 = weight row for data0..2; 3 = bias.
- wr_data_i  in  VECTOR_LEN*BW  weight row; for bias, low ACC_BW bits, signed.
- data_o  out  BW  signed result, range 0..2^(BW-1)-1.
- filter_o  out  clog2(NUM_FILTERS)  filter index of data_o.
- valid_o  out  1  result valid.
- last_o  out  1  final result of the frame.

Behaviour:
- Widths: ACC_BW = 2*BW + clog2(3*VECTOR_LEN), which is 22 at defaults. Products are full 2*BW-bit signed values, sign-extended into the accumulator. No overflow is possible.
- No backpressure, because the upstream cannot stall. Every valid_i beat is accepted.
- Counters:
  - beat_cnt runs 0..FRAME_LEN-1 and increments on valid_i only.
  - At FRAME_LEN-1 it wraps to 0 and filter_idx increments.
  - filter_idx wraps from NUM_FILTERS-1 to 0.
  - Gaps in valid_i do not change either counter.
- Pipeline, latency 3 cycles from valid_i to valid_o:
  - S1 registers the 3*VECTOR_LEN products, selected with the weights of filter_idx, plus tag {filter_idx, is_last}.
  - S2 registers the adder-tree sum plus the bias of the tagged filter.
  - S3 registers ReLU (negative becomes 0), then >>> SHIFT, then saturates to 2^(BW-1)-1. Drives data_o, filter_o, valid_o, last_o.
- is_last = valid_i && beat_cnt==FRAME_LEN-1 && filter_idx==NUM_FILTERS-1.
- Valid and tag bits travel with the data. A bubble in valid_i gives a bubble in valid_o exactly 3 cycles later.
- Weight bank:
  - NUM_FILTERS x 3 rows plus NUM_FILTERS biases; not reset.
  - A write is visible to an S1 lookup starting the following cycle.
  - Writing the filter currently in use mid-frame is legal: windows captured after the write cycle use the new values.
- Reset:
  - rst_n_i low immediately clears beat_cnt, filter_idx, all pipeline valid/last bits, and the outputs data_o, filter_o, valid_o, last_o to 0.
  - Data-path registers other than the outputs need no reset.
  - Reset mid-frame discards in-flight results. After release, the first valid_i is beat 0 of filter 0.
- last_o is high for exactly one cycle per frame, coincident with valid_o.

Decomposition:
- Shared package conv_pkg holds:
  - FILTER_LEN=3
  - ACC_BW function of BW/VECTOR_LEN
  - tap encoding constants TAP_ROW0..TAP_ROW2, TAP_BIAS
  - saturate/ReLU helper function
- One sub-module dot3_tree: registered products plus a pipelined signed adder tree for 3*VECTOR_LEN terms. It owns S1 and S2 arithmetic. conv1d_pe holds the counters, weight bank, tags and S3.

Test Plan:
- Unit value: filter0 has row0 elem0 weight 1, all other weights 0, bias 0, SHIFT=0. Drive data0 elem0=5, single valid → data_o=5, filter_o=0, valid_o high exactly 3 cycles after valid_i.
- ReLU/saturate, SHIFT=0:
  - all weights 127, all data 127 → data_o=127.
  - data0 all -128, weights 1 → data_o=0.
- Shift/bias: weight 1 on one element, data 100, bias 156, SHIFT=8 → 256>>>8, so data_o=1.
- Filter stepping: filter f bias=10*(f+1), weights 0, SHIFT=0, 400 valid beats with random gaps:
  - outputs 1-50 are 10 with filter_o=0; outputs 51-100 are 20 with filter_o=1; and so on.
  - last_o only on output 400.
  - counters restart at filter 0 on beat 401.
- Bubbles: valid_i pattern 1,0,1,1,0 → valid_o shows the same pattern shifted by 3 cycles, and beat counting is unaffected.
- Reset mid-operation: assert rst_n_i low asynchronously while 2 results are in flight, 30 beats into filter 3:
  - valid_o drops immediately and no in-flight result emerges.
  - first post-reset result has filter_o=0, and last_o appears only after 400 further beats.
